intr_vec_seq: RTL and testbench

Reset and interrupt vector sequencer for the 8-bit pipelined CPU wrapper. After reset it fetches the reset vector from memory and loads the PC. On an external interrupt it stalls fetch and drains the pipeline, then pushes the return address onto the memory stack, fetches the interrupt vector and loads the PC. It sits between the hazard/fetch logic, the PC register, the stack pointer and the unified memory port, and takes ownership of that port only while it is sequencing.

---
 rtl/intr_vec_seq.sv | 196 +++++++++++++++++++
 tb/tb_intr_vec_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_vec_seq.sv
// -----------------------------------------------------------------------------
// intr_vec_seq
//
// Reset and interrupt vector sequencer for the 8-bit pipelined CPU wrapper.
// Out of reset it reads the reset vector from memory and loads the PC. When an
// external interrupt is accepted it flushes and stalls fetch, waits for the
// pipeline to drain, pushes the return address onto the memory stack, then
// reads the interrupt vector and loads the PC. It owns the unified memory port
// only while sequencing (mem_own=1).
//
// Parameters
//   RST_VEC_ADDR  memory address holding the reset vector
//   INT_VEC_ADDR  memory address holding the interrupt vector
//   SYNC_STAGES   synchroniser depth for int_sig (2 or more)
//
// Ports
//   clk, rstn     clock; synchronous active-low reset
//   int_sig       asynchronous interrupt request, rising-edge significant
//   rti           one-cycle pulse when return-from-interrupt retires
//   pipe_empty    no instruction in flight past fetch
//   pc_ret        PC of the oldest unexecuted instruction (return address)
//   sp_in         current stack pointer
//   mem_rdata     combinational memory read data
//   mem_own       sequencer drives the memory port this cycle
//   mem_addr      memory address (valid when mem_own=1)
//   mem_wdata     memory write data
//   mem_we        memory write enable
//   pc_load       load PC with pc_value at the next edge
//   pc_value      new PC value
//   sp_dec        decrement SP at the next edge
//   stall         hold fetch and PC
//   flush         kill the instruction in fetch/decode (one-cycle pulse)
//   busy          high in every state except IDLE
// -----------------------------------------------------------------------------
module intr_vec_seq #(
    parameter logic [7:0] RST_VEC_ADDR = 8'h00,
    parameter logic [7:0] INT_VEC_ADDR = 8'h01,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       int_sig,
    input  logic       rti,
    input  logic       pipe_empty,
    input  logic [7:0] pc_ret,
    input  logic [7:0] sp_in,
    input  logic [7:0] mem_rdata,
    output logic       mem_own,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       pc_load,
    output logic [7:0] pc_value,
    output logic       sp_dec,
    output logic       stall,
    output logic       flush,
    output logic       busy
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        IDLE  = 3'd1,
        DRAIN = 3'd2,
        PUSH  = 3'd3,
        VECT  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    state_t                 out_state;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_prev_q, sync_prev_d;
    logic                   pending_q, pending_d;
    logic                   int_en_q, int_en_d;
    logic [7:0]             ret_addr_q, ret_addr_d;
    logic                   int_rise;

    // Synchroniser shift chain; the oldest stage feeds the edge detector.
    assign sync_d      = {sync_q[SYNC_STAGES-2:0], int_sig};
    assign sync_prev_d = sync_q[SYNC_STAGES-1];
    assign int_rise    = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= BOOT;
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            int_en_q    <= 1'b1;
            ret_addr_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            sync_prev_q <= sync_prev_d;
            pending_q   <= pending_d;
            int_en_q    <= int_en_d;
            ret_addr_q  <= ret_addr_d;
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default before the case statement, so no
    // path leaves a combinational output unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        int_en_d   = int_en_q;
        ret_addr_d = ret_addr_q;

        // One-deep request latch: later edges merge into the pending request.
        if (int_rise) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            BOOT: state_d = IDLE;
            IDLE: begin
                if (pending_q && int_en_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    ret_addr_d = pc_ret;
                    state_d    = PUSH;
                end
            end
            PUSH: state_d = VECT;
            VECT: begin
                // Clearing here wins over a same-cycle edge, which is dropped.
                pending_d = 1'b0;
                int_en_d  = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = BOOT;
        endcase

        if (rti) begin
            int_en_d = 1'b1;
        end
    end

    // While rstn is low the outputs present the reset image (BOOT without the
    // vector data), so a PUSH cut short by reset never issues its write.
    assign out_state = rstn ? state_q : BOOT;

    always_comb begin
        mem_own   = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        pc_load   = 1'b0;
        pc_value  = 8'h00;
        sp_dec    = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        busy      = 1'b1;

        unique case (out_state)
            BOOT: begin
                mem_own  = 1'b1;
                mem_addr = RST_VEC_ADDR;
                pc_load  = 1'b1;
                pc_value = rstn ? mem_rdata : 8'h00;
                stall    = 1'b1;
            end
            IDLE: begin
                busy  = 1'b0;
                flush = pending_q & int_en_q;
            end
            DRAIN: begin
                stall = 1'b1;
            end
            PUSH: begin
                mem_own   = 1'b1;
                mem_addr  = sp_in;
                mem_wdata = ret_addr_q;
                mem_we    = 1'b1;
                sp_dec    = 1'b1;
                stall     = 1'b1;
            end
            VECT: begin
                mem_own  = 1'b1;
                mem_addr = INT_VEC_ADDR;
                pc_load  = 1'b1;
                pc_value = mem_rdata;
                stall    = 1'b1;
            end
            default: begin
                stall = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_intr_vec_seq.sv
// -----------------------------------------------------------------------------
// tb_intr_vec_seq
//
// Directed bench for intr_vec_seq. A small memory/PC/stack model surrounds the
// DUT: memory reads are combinational, writes, PC loads and SP decrements are
// recorded on the clock edge. A table of per-cycle vectors covers reset, boot
// and a full interrupt service; hand-written sequences cover the multi-cycle
// corner cases. Inputs are driven 1 ns after the rising edge and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_intr_vec_seq;

    logic       clk = 1'b0;
    logic       rstn, int_sig, rti, pipe_empty;
    logic [7:0] pc_ret, sp_in, mem_rdata;
    logic       mem_own, mem_we, pc_load, sp_dec, stall, flush, busy;
    logic [7:0] mem_addr, mem_wdata, pc_value;

    always #5 clk = ~clk;

    intr_vec_seq dut (
        .clk        (clk),
        .rstn       (rstn),
        .int_sig    (int_sig),
        .rti        (rti),
        .pipe_empty (pipe_empty),
        .pc_ret     (pc_ret),
        .sp_in      (sp_in),
        .mem_rdata  (mem_rdata),
        .mem_own    (mem_own),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .pc_load    (pc_load),
        .pc_value   (pc_value),
        .sp_dec     (sp_dec),
        .stall      (stall),
        .flush      (flush),
        .busy       (busy)
    );

    // Memory model: only the two vector locations hold meaningful data.
    localparam logic [7:0] RST_VEC = 8'h10;
    localparam logic [7:0] INT_VEC = 8'h40;
    always_comb begin
        if (mem_addr == 8'h00)      mem_rdata = RST_VEC;
        else if (mem_addr == 8'h01) mem_rdata = INT_VEC;
        else                        mem_rdata = 8'hEE;
    end

    logic [7:0] pc;
    logic [7:0] waddr, wdata;
    int         we_cnt    = 0;
    int         dec_cnt   = 0;
    int         flush_cnt = 0;

    always @(posedge clk) begin
        if (pc_load) pc <= pc_value;
        if (sp_dec)  dec_cnt <= dec_cnt + 1;
        if (flush)   flush_cnt <= flush_cnt + 1;
        if (mem_own && mem_we) begin
            we_cnt <= we_cnt + 1;
            waddr  <= mem_addr;
            wdata  <= mem_wdata;
        end
    end

    typedef struct packed {
        logic       own;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       we;
        logic       pc_load;
        logic [7:0] pc_value;
        logic       sp_dec;
        logic       stall;
        logic       flush;
        logic       busy;
    } outs_t;

    typedef struct {
        logic  rstn;
        logic  int_sig;
        logic  pipe_empty;
        logic  rti;
        outs_t exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic outs_t mk(input logic own, input logic [7:0] addr, input logic [7:0] wd,
                                 input logic we, input logic pcl, input logic [7:0] pcv,
                                 input logic spd, input logic st, input logic fl, input logic bz);
        outs_t o;
        o = '{own, addr, wd, we, pcl, pcv, spd, st, fl, bz};
        return o;
    endfunction

    function automatic outs_t cur();
        outs_t o;
        o = '{mem_own, mem_addr, mem_wdata, mem_we, pc_load, pc_value, sp_dec, stall, flush, busy};
        return o;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t  tbl[15];
    outs_t o_rst, o_boot, o_zero, o_flush, o_drain, o_push, o_vect;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int base_flush, base_we;

        o_rst   = mk(1, 8'h00, 8'h00, 0, 1, 8'h00, 0, 1, 0, 1);
        o_boot  = mk(1, 8'h00, 8'h00, 0, 1, RST_VEC, 0, 1, 0, 1);
        o_zero  = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        o_flush = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0);
        o_drain = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 1);
        o_push  = mk(1, 8'hFF, 8'h13, 1, 0, 8'h00, 1, 1, 0, 1);
        o_vect  = mk(1, 8'h01, 8'h00, 0, 1, INT_VEC, 0, 1, 0, 1);

        //             rstn int  pe  rti  expected
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, o_rst};    // in reset
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, o_rst};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, o_boot};   // BOOT, vector on pc_value
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, o_zero};   // IDLE
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, o_zero};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, o_zero};   // int_sig rises
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, o_zero};   // after edge 1
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, o_zero};   // after edge 2
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, o_flush};  // edge 3: pending, flush
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, o_drain};  // edge 4: DRAIN
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, o_push};   // edge 5: PUSH
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, o_vect};   // edge 6: VECT
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, o_zero};   // edge 7: IDLE, held high
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, o_zero};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, o_zero};

        rti    = 1'b0;
        pc_ret = 8'h13;
        sp_in  = 8'hFF;

        for (int i = 0; i < 15; i++) begin
            rstn       = tbl[i].rstn;
            int_sig    = tbl[i].int_sig;
            pipe_empty = tbl[i].pipe_empty;
            rti        = tbl[i].rti;
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(cur()), 64'(tbl[i].exp));
            if (i == 3) check("boot_pc", 64'(pc), 64'(RST_VEC));
            next_cycle();
        end
        check("svc1_pc", 64'(pc), 64'(INT_VEC));
        check("svc1_we_cnt", 64'(we_cnt), 64'd1);
        check("svc1_waddr", 64'(waddr), 64'hFF);
        check("svc1_wdata", 64'(wdata), 64'h13);
        check("svc1_dec_cnt", 64'(dec_cnt), 64'd1);
        check("svc1_flush_cnt", 64'(flush_cnt), 64'd1);

        // Interrupts now disabled: a fresh edge is latched but not serviced.
        int_sig = 1'b0;
        sp_in   = 8'hFE;
        repeat (3) next_cycle();
        int_sig = 1'b1;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy || flush) found = 1'b1;
            next_cycle();
            int_sig = 1'b0;
        end
        check("masked_no_service", 64'(found), 64'd0);

        // rti with pending in the same IDLE cycle: service starts one edge later.
        pipe_empty = 1'b0;
        rti        = 1'b1;
        @(negedge clk);
        check("rti_cycle_no_flush", 64'(flush), 64'd0);
        next_cycle();
        rti = 1'b0;
        @(negedge clk);
        check("rti_next_flush", 64'(flush), 64'd1);
        next_cycle();

        // Stretched drain: stall held, no memory access, pc_ret changing.
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pc_ret = 8'h20 + 8'(k);
            @(negedge clk);
            if ({mem_own, mem_we, stall, busy} !== 4'b0011) found = 1'b1;
            next_cycle();
        end
        check("drain_hold", 64'(found), 64'd0);
        pc_ret     = 8'h55;
        pipe_empty = 1'b1;
        @(negedge clk);
        check("drain_last", 64'(cur()), 64'(o_drain));
        next_cycle();
        pc_ret = 8'h99;
        @(negedge clk);
        check("push2", 64'(cur()), 64'(mk(1, 8'hFE, 8'h55, 1, 0, 8'h00, 1, 1, 0, 1)));
        next_cycle();
        @(negedge clk);
        check("vect2", 64'(cur()), 64'(o_vect));
        next_cycle();
        check("svc2_we_cnt", 64'(we_cnt), 64'd2);
        check("svc2_dec_cnt", 64'(dec_cnt), 64'd2);

        // Reset while draining: no write, PC reloaded, pending dropped.
        rti = 1'b1;
        next_cycle();
        rti        = 1'b0;
        pipe_empty = 1'b0;
        int_sig    = 1'b1;
        next_cycle();
        next_cycle();
        int_sig = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (busy && stall && !mem_own) found = 1'b1;
            next_cycle();
        end
        check("reach_drain", 64'(found), 64'd1);
        base_flush = flush_cnt;
        base_we    = we_cnt;
        rstn = 1'b0;
        @(negedge clk);
        check("rst_in_drain", 64'(cur()), 64'(o_rst));
        next_cycle();
        rstn       = 1'b1;
        pipe_empty = 1'b1;
        @(negedge clk);
        check("reboot", 64'(cur()), 64'(o_boot));
        next_cycle();
        check("reboot_pc", 64'(pc), 64'(RST_VEC));
        repeat (10) next_cycle();
        check("rst_no_flush", 64'(flush_cnt), 64'(base_flush));
        check("rst_no_write", 64'(we_cnt), 64'(base_we));

        // Stack pointer at 0x00: write lands at 0x00, vector still loads.
        sp_in   = 8'h00;
        pc_ret  = 8'h77;
        int_sig = 1'b1;
        next_cycle();
        next_cycle();
        int_sig = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (mem_we) found = 1'b1;
            else next_cycle();
        end
        check("sp0_push_seen", 64'(found), 64'd1);
        check("sp0_push", 64'(cur()), 64'(mk(1, 8'h00, 8'h77, 1, 0, 8'h00, 1, 1, 0, 1)));
        next_cycle();
        @(negedge clk);
        check("sp0_vect", 64'(cur()), 64'(o_vect));
        next_cycle();
        check("sp0_pc", 64'(pc), 64'(INT_VEC));
        check("sp0_waddr", 64'(waddr), 64'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
